// File: rtl/clock_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : clock_pkg
// Purpose  : Shared types and constants for the clock set sequencer.
//            Optional feature macro: CLKSEQ_DATE_ADVANCE_EN (enables ADV).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package clock_pkg;

  localparam int HR_MOD  = 24;
  localparam int MIN_MOD = 60;
  localparam int HR_W    = 5;
  localparam int MIN_W   = 6;
  localparam int CNT_W   = 6;   // per-phase pulse counter width
  localparam int ADV_W   = 16;  // day-advance hour pulse counter width

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADV   = 3'd1,
    S_MIN   = 3'd2,
    S_HR    = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/clock_set_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : clock_set_sequencer_if
// Purpose  : Host request/target, clock readback and set-pulse bundle.
//            Optional feature macro: CLKSEQ_DATE_ADVANCE_EN (adds adv_days).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface clock_set_sequencer_if;
  import clock_pkg::*;

  logic             req;
  logic [HR_W-1:0]  target_hr;
  logic [MIN_W-1:0] target_min;
  logic [5:0]       cur_hr;
  logic [MIN_W-1:0] cur_min;
  logic             add_hour;
  logic             add_minute;
  logic             busy;
  logic             done;
  logic             err;
`ifdef CLKSEQ_DATE_ADVANCE_EN
  logic [10:0]      adv_days;
`endif

  // Host / clock side
  modport master (
`ifdef CLKSEQ_DATE_ADVANCE_EN
    output adv_days,
`endif
    output req, target_hr, target_min, cur_hr, cur_min,
    input  add_hour, add_minute, busy, done, err
  );

  // Sequencer side
  modport slave (
`ifdef CLKSEQ_DATE_ADVANCE_EN
    input  adv_days,
`endif
    input  req, target_hr, target_min, cur_hr, cur_min,
    output add_hour, add_minute, busy, done, err
  );

endinterface
`default_nettype wire

// File: rtl/clock_set_sequencer_pulse_spacer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pulse_spacer
// Purpose  : Emits one registered set pulse per fire request, then holds off
//            for PULSE_GAP cycles; gap_done marks the final gap cycle.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module pulse_spacer #(
  parameter int PULSE_GAP = 2
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_fire,
  input  wire logic i_sel_hr,
  output logic      o_add_hour,
  output logic      o_add_minute,
  output logic      o_gap_done,
  output logic      o_idle
);

  localparam int c_GAP_W = (PULSE_GAP < 1) ? 1 : $clog2(PULSE_GAP + 1);

  logic               r_add_hour;
  logic               r_add_minute;
  logic               r_active;
  logic [c_GAP_W-1:0] r_cnt;

  // Pulse register plus gap countdown; a fire on the gap_done cycle reloads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_add_hour   <= 1'b0;
      r_add_minute <= 1'b0;
      r_active     <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_add_hour   <= i_fire & i_sel_hr;
      r_add_minute <= i_fire & ~i_sel_hr;
      if (i_fire) begin
        r_active <= 1'b1;
        r_cnt    <= c_GAP_W'(PULSE_GAP);
      end else if (r_active) begin
        if (r_cnt == '0) begin
          r_active <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign o_add_hour   = r_add_hour;
  assign o_add_minute = r_add_minute;
  assign o_gap_done   = r_active && (r_cnt == '0);
  assign o_idle       = ~r_active;

endmodule
`default_nettype wire

// File: rtl/clock_set_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : clock_set_sequencer
// Purpose  : Drives add_minute / add_hour pulses until the clock readback
//            equals a requested 24-hour time, retrying on natural ticks.
//            Optional feature macro: CLKSEQ_DATE_ADVANCE_EN (day advance).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module clock_set_sequencer
  import clock_pkg::*;
#(
  parameter int PULSE_GAP = 2,
  parameter int MAX_RETRY = 3
) (
  input  wire logic              clk,
  input  wire logic              reset,
  clock_set_sequencer_if.slave   io_seq
);

  localparam int c_RETRY_W = $clog2(MAX_RETRY + 2);

  seq_state_t           r_state;
  seq_state_t           w_next;
  logic [HR_W-1:0]      r_tgt_hr;
  logic [MIN_W-1:0]     r_tgt_min;
  logic [CNT_W-1:0]     r_pcnt;
  logic [c_RETRY_W-1:0] r_retry;

  logic w_fire;
  logic w_sel_hr;
  logic w_capture;
  logic w_pcnt_clr;
  logic w_retry_inc;
  logic w_ready;
  logic w_gap_done;
  logic w_idle;
  logic w_add_hour;
  logic w_add_minute;
  logic w_hr_match;
  logic w_min_match;
  logic w_bad_target;
`ifdef CLKSEQ_DATE_ADVANCE_EN
  logic [ADV_W-1:0] r_adv;
  logic             w_adv_dec;
`endif

  pulse_spacer #(
    .PULSE_GAP (PULSE_GAP)
  ) u_spacer (
    .clk          (clk),
    .reset        (reset),
    .i_fire       (w_fire),
    .i_sel_hr     (w_sel_hr),
    .o_add_hour   (w_add_hour),
    .o_add_minute (w_add_minute),
    .o_gap_done   (w_gap_done),
    .o_idle       (w_idle)
  );

  // Readback is only trusted when no pulse is in flight or its gap has elapsed
  assign w_ready      = w_idle | w_gap_done;
  assign w_hr_match   = (io_seq.cur_hr == {1'b0, r_tgt_hr});
  assign w_min_match  = (io_seq.cur_min == r_tgt_min);
  assign w_bad_target = (io_seq.target_hr > HR_W'(HR_MOD - 1)) ||
                        (io_seq.target_min > MIN_W'(MIN_MOD - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_next      = r_state;
    w_fire      = 1'b0;
    w_sel_hr    = 1'b0;
    w_capture   = 1'b0;
    w_pcnt_clr  = 1'b0;
    w_retry_inc = 1'b0;
`ifdef CLKSEQ_DATE_ADVANCE_EN
    w_adv_dec   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (io_seq.req) begin
          if (w_bad_target) begin
            w_next = S_ERR;
          end else begin
            w_capture = 1'b1;
`ifdef CLKSEQ_DATE_ADVANCE_EN
            w_next = S_ADV;
`else
            w_next = S_MIN;
`endif
          end
        end
      end
`ifdef CLKSEQ_DATE_ADVANCE_EN
      S_ADV: begin
        // Blind hour pulses; no readback compare in this phase
        if (w_ready) begin
          if (r_adv == '0) begin
            w_next     = S_MIN;
            w_pcnt_clr = 1'b1;
          end else begin
            w_fire    = 1'b1;
            w_sel_hr  = 1'b1;
            w_adv_dec = 1'b1;
          end
        end
      end
`endif
      S_MIN: begin
        if (w_ready) begin
          if (w_min_match) begin
            w_next     = S_HR;
            w_pcnt_clr = 1'b1;
          end else if (r_pcnt == CNT_W'(MIN_MOD)) begin
            w_next = S_ERR;
          end else begin
            w_fire = 1'b1;
          end
        end
      end
      S_HR: begin
        if (w_ready) begin
          if (w_hr_match) begin
            w_next = S_CHECK;
          end else if (r_pcnt == CNT_W'(HR_MOD)) begin
            w_next = S_ERR;
          end else begin
            w_fire   = 1'b1;
            w_sel_hr = 1'b1;
          end
        end
      end
      S_CHECK: begin
        // A natural minute tick between phases shows up as a mismatch here
        if (w_hr_match && w_min_match) begin
          w_next = S_DONE;
        end else begin
          w_retry_inc = 1'b1;
          if (r_retry == c_RETRY_W'(MAX_RETRY)) begin
            w_next = S_ERR;
          end else begin
            w_next     = S_MIN;
            w_pcnt_clr = 1'b1;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Target capture, per-phase pulse count and retry count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tgt_hr  <= '0;
      r_tgt_min <= '0;
      r_pcnt    <= '0;
      r_retry   <= '0;
    end else begin
      if (w_capture) begin
        r_tgt_hr  <= io_seq.target_hr;
        r_tgt_min <= io_seq.target_min;
      end
      if (w_capture || w_pcnt_clr) begin
        r_pcnt <= '0;
      end else if (w_fire) begin
        r_pcnt <= r_pcnt + 1'b1;
      end
      if (w_capture) begin
        r_retry <= '0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + 1'b1;
      end
    end
  end

`ifdef CLKSEQ_DATE_ADVANCE_EN
  // Remaining day-advance hour pulses, loaded as 24 per requested day
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_adv <= '0;
    end else if (w_capture) begin
      r_adv <= ADV_W'(io_seq.adv_days) * ADV_W'(HR_MOD);
    end else if (w_adv_dec) begin
      r_adv <= r_adv - 1'b1;
    end
  end
`endif

  assign io_seq.add_hour   = w_add_hour;
  assign io_seq.add_minute = w_add_minute;
  assign io_seq.busy       = (r_state == S_ADV) || (r_state == S_MIN) ||
                             (r_state == S_HR)  || (r_state == S_CHECK);
  assign io_seq.done       = (r_state == S_DONE);
  assign io_seq.err        = (r_state == S_ERR);

endmodule
`default_nettype wire
